// File: rtl/uart_rx_pkg.sv
// Shared types and constants for the UART receive frame controller.
// Optional break detection is enabled with the UART_BREAK_DETECT_EN macro.
package uart_rx_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP,
        BRK_WAIT
    } rx_state_e;

    localparam logic [5:0] PRESCALE_8  = 6'd8;
    localparam logic [5:0] PRESCALE_16 = 6'd16;
    localparam logic [5:0] PRESCALE_32 = 6'd32;

    localparam int BIT_CNT_W = 4;

endpackage

// File: rtl/uart_rx_edge_bit_counter.sv
// Oversampling edge counter and bit counter for one UART frame.
// edge_cnt wraps at prescale-1, which also advances bit_cnt; clear wins over enable.
module uart_rx_edge_bit_counter
    import uart_rx_pkg::*;
(
    input  logic                 clk_i,
    input  logic                 rst_n_i,
    input  logic                 en_i,
    input  logic                 clr_i,
    input  logic [5:0]           prescale_i,
    output logic [5:0]           edge_cnt_o,
    output logic [BIT_CNT_W-1:0] bit_cnt_o,
    output logic                 eob_o
);

    logic [5:0]           edge_q;
    logic [BIT_CNT_W-1:0] bit_q;

    assign eob_o      = (edge_q == (prescale_i - 6'd1));
    assign edge_cnt_o = edge_q;
    assign bit_cnt_o  = bit_q;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            edge_q <= '0;
            bit_q  <= '0;
        end else if (clr_i) begin
            edge_q <= '0;
            bit_q  <= '0;
        end else if (en_i) begin
            if (eob_o) begin
                edge_q <= '0;
                bit_q  <= bit_q + BIT_CNT_W'(1);
            end else begin
                edge_q <= edge_q + 6'd1;
            end
        end
    end

endmodule

// File: rtl/uart_rx_ctrl.sv
// UART receive frame controller: start detect, LSB-first shift, parity/stop checks.
// Define UART_BREAK_DETECT_EN to add the brk_det output and the BRK_WAIT recovery state.
module uart_rx_ctrl #(
    parameter int DATA = 8
) (
    input  logic                             CLK,
    input  logic                             RST,
    input  logic                             RX_IN,
    input  logic [5:0]                       prescale,
    input  logic                             PAR_EN,
    input  logic                             PAR_TYP,
    input  logic                             sampled_bit,
    input  logic                             sample_done,
    output logic                             data_sample_en,
    output logic [5:0]                       edge_cnt,
    output logic [uart_rx_pkg::BIT_CNT_W-1:0] bit_cnt,
    output logic [DATA-1:0]                  P_DATA,
    output logic                             data_valid,
    output logic                             par_err,
    output logic                             stp_err
`ifdef UART_BREAK_DETECT_EN
    ,
    output logic                             brk_det
`endif
);
    import uart_rx_pkg::*;

    rx_state_e       state_q;
    logic [DATA-1:0] shift_q, pdata_q;
    logic            dv_q, pe_q, se_q, dse_q;
    logic            par_en_q, par_typ_q, bad_q;
    logic            eob, cnt_clr, brk_hit;
    logic            unused_sample_done;

    assign unused_sample_done = sample_done;

    // Counters sit at zero whenever the FSM is, or is about to be, idle.
    assign cnt_clr = (state_q == IDLE) || (state_q == BRK_WAIT) ||
                     (eob && ((state_q == STOP) || ((state_q == START) && sampled_bit)));

    uart_rx_edge_bit_counter u_cnt (
        .clk_i      (CLK),
        .rst_n_i    (RST),
        .en_i       (state_q != IDLE),
        .clr_i      (cnt_clr),
        .prescale_i (prescale),
        .edge_cnt_o (edge_cnt),
        .bit_cnt_o  (bit_cnt),
        .eob_o      (eob)
    );

`ifdef UART_BREAK_DETECT_EN
    logic par_bit_q, bk_q;

    assign brk_hit = !sampled_bit && (shift_q == '0) && !(par_en_q && par_bit_q);
    assign brk_det = bk_q;

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            par_bit_q <= 1'b0;
            bk_q      <= 1'b0;
        end else begin
            bk_q <= (state_q == STOP) && eob && brk_hit;
            if ((state_q == PARITY) && eob)
                par_bit_q <= sampled_bit;
        end
    end
`else
    assign brk_hit = 1'b0;
`endif

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q   <= IDLE;
            shift_q   <= '0;
            pdata_q   <= '0;
            dv_q      <= 1'b0;
            pe_q      <= 1'b0;
            se_q      <= 1'b0;
            dse_q     <= 1'b0;
            par_en_q  <= 1'b0;
            par_typ_q <= 1'b0;
            bad_q     <= 1'b0;
        end else begin
            dv_q <= 1'b0;
            pe_q <= 1'b0;
            se_q <= 1'b0;
            case (state_q)
                IDLE: if (!RX_IN) begin
                    state_q   <= START;
                    dse_q     <= 1'b1;
                    par_en_q  <= PAR_EN;
                    par_typ_q <= PAR_TYP;
                    bad_q     <= 1'b0;
                end
                START: if (eob) begin
                    if (sampled_bit) begin
                        state_q <= IDLE;
                        dse_q   <= 1'b0;
                    end else begin
                        state_q <= uart_rx_pkg::DATA;
                    end
                end
                uart_rx_pkg::DATA: if (eob) begin
                    shift_q <= {sampled_bit, shift_q[DATA-1:1]};
                    if (bit_cnt == BIT_CNT_W'(DATA))
                        state_q <= par_en_q ? PARITY : STOP;
                end
                PARITY: if (eob) begin
                    if (sampled_bit != (^shift_q ^ par_typ_q)) begin
                        pe_q  <= 1'b1;
                        bad_q <= 1'b1;
                    end
                    state_q <= STOP;
                end
                STOP: if (eob) begin
                    dse_q <= 1'b0;
                    if (brk_hit) begin
                        state_q <= BRK_WAIT;
                    end else begin
                        se_q    <= ~sampled_bit;
                        state_q <= IDLE;
                        if (sampled_bit && !bad_q) begin
                            pdata_q <= shift_q;
                            dv_q    <= 1'b1;
                        end
                    end
                end
                BRK_WAIT: if (RX_IN) state_q <= IDLE;
                default: begin
                    state_q <= IDLE;
                    dse_q   <= 1'b0;
                end
            endcase
        end
    end

    assign data_sample_en = dse_q;
    assign P_DATA         = pdata_q;
    assign data_valid     = dv_q;
    assign par_err        = pe_q;
    assign stp_err        = se_q;

endmodule

// File: tb/tb_uart_rx_ctrl.sv
module tb_uart_rx_ctrl;

  localparam int DATA = 8;

  logic            CLK = 1'b0;
  logic            RST = 1'b0;
  logic            RX_IN = 1'b1;
  logic [5:0]      prescale = 6'd8;
  logic            PAR_EN = 1'b0;
  logic            PAR_TYP = 1'b0;
  logic            sampled_bit = 1'b1;
  logic            sample_done = 1'b0;
  logic            data_sample_en;
  logic [5:0]      edge_cnt;
  logic [3:0]      bit_cnt;
  logic [DATA-1:0] P_DATA;
  logic            data_valid, par_err, stp_err;
`ifdef UART_BREAK_DETECT_EN
  logic            brk_det;
  int              n_bk = 0;
`endif

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int n_dv = 0, n_pe = 0, n_se = 0;
  int dv_cyc = 0;
  int t0 = 0;
  logic [7:0] dv_log[$];

  uart_rx_ctrl #(.DATA(DATA)) dut (
    .CLK            (CLK),
    .RST            (RST),
    .RX_IN          (RX_IN),
    .prescale       (prescale),
    .PAR_EN         (PAR_EN),
    .PAR_TYP        (PAR_TYP),
    .sampled_bit    (sampled_bit),
    .sample_done    (sample_done),
    .data_sample_en (data_sample_en),
    .edge_cnt       (edge_cnt),
    .bit_cnt        (bit_cnt),
    .P_DATA         (P_DATA),
    .data_valid     (data_valid),
    .par_err        (par_err),
    .stp_err        (stp_err)
`ifdef UART_BREAK_DETECT_EN
    ,
    .brk_det        (brk_det)
`endif
  );

  always #5 CLK = ~CLK;

  always @(posedge CLK) cyc <= cyc + 1;

  always @(negedge CLK) begin
    if (data_valid) begin
      n_dv   <= n_dv + 1;
      dv_cyc <= cyc;
      dv_log.push_back(P_DATA);
    end
    if (par_err) n_pe <= n_pe + 1;
    if (stp_err) n_se <= n_se + 1;
`ifdef UART_BREAK_DETECT_EN
    if (brk_det) n_bk <= n_bk + 1;
`endif
  end

  task automatic fail(input string tag);
    errors++;
    $error("FAIL %s", tag);
  endtask

  task automatic send_bits(input logic [10:0] bits, input int n, input int p);
    t0 = cyc + 1;
    for (int j = 0; j < n; j++) begin
      RX_IN = bits[j];
      repeat (p - 1) @(negedge CLK);
      sampled_bit = bits[j];
      @(negedge CLK);
    end
  endtask

  task automatic send_frame(input logic [7:0] d, input logic pe, input logic pb,
                            input logic stop, input int p);
    if (pe) send_bits({stop, pb, d, 1'b0}, 11, p);
    else    send_bits({1'b0, stop, d, 1'b0}, 10, p);
  endtask

  function automatic int n_se_expected();
`ifdef UART_BREAK_DETECT_EN
    return 1;
`else
    return 2;
`endif
  endfunction

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(negedge CLK);
    #1;
    checks++; if (data_sample_en !== 1'b0) fail("rst_dse");
    checks++; if (edge_cnt !== 6'd0) fail("rst_edge");
    checks++; if (bit_cnt !== 4'd0) fail("rst_bit");
    checks++; if (P_DATA !== 8'h00) fail("rst_pdata");
    checks++; if (data_valid !== 1'b0) fail("rst_dv");
    RST = 1'b1;
    @(negedge CLK);

    prescale = 6'd8;
    PAR_EN = 1'b0;
    send_frame(8'hA5, 1'b0, 1'b0, 1'b1, 8);
    repeat (4) @(negedge CLK);
    #1;
    checks++; if (n_dv !== 1) fail("a5_dv_cnt");
    checks++; if (P_DATA !== 8'hA5) fail("a5_pdata");
    checks++; if (dv_cyc - t0 !== 80) fail("a5_latency");
    checks++; if (n_se !== 0) fail("a5_stp");

    prescale = 6'd16;
    PAR_EN = 1'b1;
    PAR_TYP = 1'b0;
    send_frame(8'h3C, 1'b1, 1'b0, 1'b1, 16);
    repeat (4) @(negedge CLK);
    #1;
    checks++; if (n_dv !== 2) fail("par_ok_dv");
    checks++; if (P_DATA !== 8'h3C) fail("par_ok_pdata");
    checks++; if (dv_cyc - t0 !== 176) fail("par_ok_latency");
    checks++; if (n_pe !== 0) fail("par_ok_pe");
    send_frame(8'h3C, 1'b1, 1'b1, 1'b1, 16);
    repeat (4) @(negedge CLK);
    #1;
    checks++; if (n_pe !== 1) fail("par_bad_pe");
    checks++; if (n_dv !== 2) fail("par_bad_dv");
    checks++; if (P_DATA !== 8'h3C) fail("par_bad_pdata");

    prescale = 6'd8;
    PAR_EN = 1'b0;
    sampled_bit = 1'b1;
    RX_IN = 1'b0;
    repeat (3) @(negedge CLK);
    RX_IN = 1'b1;
    @(negedge CLK);
    #1;
    checks++; if (edge_cnt !== 6'd3) fail("glitch_edge3");
    checks++; if (data_sample_en !== 1'b1) fail("glitch_dse_on");
    repeat (5) @(negedge CLK);
    #1;
    checks++; if (data_sample_en !== 1'b0) fail("glitch_dse_off");
    checks++; if (edge_cnt !== 6'd0) fail("glitch_edge0");
    checks++; if (n_dv !== 2) fail("glitch_dv");
    checks++; if (n_se !== 0) fail("glitch_se");
    checks++; if (n_pe !== 1) fail("glitch_pe");

    prescale = 6'd32;
    send_frame(8'h81, 1'b0, 1'b0, 1'b0, 32);
    RX_IN = 1'b1;
    repeat (4) @(negedge CLK);
    #1;
    checks++; if (n_se !== 1) fail("stp_81_se");
    checks++; if (n_dv !== 2) fail("stp_81_dv");

    prescale = 6'd8;
    send_frame(8'h00, 1'b0, 1'b0, 1'b0, 8);
`ifdef UART_BREAK_DETECT_EN
    repeat (20) @(negedge CLK);
    #1;
    checks++; if (n_bk !== 1) fail("brk_cnt");
    checks++; if (n_se !== 1) fail("brk_se");
    checks++; if (data_sample_en !== 1'b0) fail("brk_dse");
    RX_IN = 1'b1;
    repeat (3) @(negedge CLK);
    #1;
    checks++; if (data_sample_en !== 1'b0) fail("brk_release_dse");
`else
    RX_IN = 1'b1;
    repeat (4) @(negedge CLK);
    #1;
    checks++; if (n_se !== 2) fail("zero_se");
`endif
    checks++; if (n_dv !== 2) fail("zero_dv");
    checks++; if (P_DATA !== 8'h3C) fail("zero_pdata");

    dv_log.delete();
    send_frame(8'h55, 1'b0, 1'b0, 1'b1, 8);
    send_frame(8'hAA, 1'b0, 1'b0, 1'b1, 8);
    repeat (4) @(negedge CLK);
    #1;
    checks++; if (n_dv !== 4) fail("b2b_dv");
    checks++; if (dv_log.size() !== 2) fail("b2b_n");
    checks++; if (((dv_log.size() > 0) ? dv_log[0] : 8'hxx) !== 8'h55) fail("b2b_first");
    checks++; if (((dv_log.size() > 1) ? dv_log[1] : 8'hxx) !== 8'hAA) fail("b2b_second");

    send_bits(11'b000_0000_1110, 4, 8);
    RX_IN = 1'b1;
    repeat (3) @(negedge CLK);
    #1;
    checks++; if (bit_cnt !== 4'd4) fail("mid_bitcnt");
    checks++; if (data_sample_en !== 1'b1) fail("mid_dse");
    RST = 1'b0;
    @(negedge CLK);
    #1;
    checks++; if (data_sample_en !== 1'b0) fail("mid_rst_dse");
    checks++; if (edge_cnt !== 6'd0) fail("mid_rst_edge");
    checks++; if (bit_cnt !== 4'd0) fail("mid_rst_bit");
    checks++; if (P_DATA !== 8'h00) fail("mid_rst_pdata");
    checks++; if (n_dv !== 4) fail("mid_rst_dv");
    RST = 1'b1;
    @(negedge CLK);
    send_frame(8'h0F, 1'b0, 1'b0, 1'b1, 8);
    repeat (4) @(negedge CLK);
    #1;
    checks++; if (n_dv !== 5) fail("post_rst_dv");
    checks++; if (P_DATA !== 8'h0F) fail("post_rst_pdata");
    checks++; if (n_se !== n_se_expected()) fail("post_rst_se");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
